gcd_unit: RTL and testbench
===========================

Name: gcd_unit

Overview:
- Parametrised, self-contained GCD engine: the next generation of the split datapath/controller GCD pair.
- Operands are loaded in parallel on a single start handshake instead of sequentially over a shared data bus.
- Operand width is configurable, and the algorithm is selected at build time: subtractive Euclid or binary (Stein).
- Provides busy/done status, a held result and an iteration count, so it can be driven directly by a testbench or a host FSM.

Parameters:
- WIDTH, 16, operand/result width in bits (>=2).
- MODE, 0, algorithm select: 0 = subtractive Euclid, 1 = binary Stein.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a_in  input  WIDTH  operand A, captured on the accepting edge.
- b_in  input  WIDTH  operand B, captured on the accepting edge.
- busy  output  1  high from the accepting edge until done is asserted.
- done  output  1  one-cycle pulse; gcd_out and iter_count are valid.
- gcd_out  output  WIDTH  result, held until the next accepted start.
- iter_count  output  WIDTH  number of reduction steps, held with gcd_out.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE; busy=0, done=0, gcd_out=0, iter_count=0.
  - Internal A, B, k and step counter are cleared.
  - Reset mid-computation abandons the operation; no done pulse is produced.
- States:
  - IDLE: start=1 -> capture A=a_in, B=b_in, k=0, step=0; go CALC; busy=1 from the next cycle. start=0 -> stay.
  - CALC: one step per clock, or termination (see below).
  - DONE: done=1 and busy=0 for exactly one cycle; go IDLE.
- Termination test, evaluated in CALC before any step:
  - MODE 0: A==0, B==0 or A==B -> result = (A==0) ? B : A.
  - MODE 1: A==0 or B==0 -> result = (A|B) << k.
  - On termination: register result into gcd_out and step into iter_count; go DONE.
  - A step is not performed in the terminating cycle.
- MODE 0 step: if A>B then A=A-B, else B=B-A. step++.
- MODE 1 step, in priority order; step++ in every case:
  - Both even: A>>=1, B>>=1, k++.
  - A even: A>>=1.
  - B even: B>>=1.
  - Both odd: if A>=B then A=(A-B)>>1, else B=(B-A)>>1.
  - k width is clog2(WIDTH)+1; the final shift is truncated to WIDTH bits, which cannot overflow for a valid gcd.
- Arithmetic: unsigned; subtractions never underflow given the comparisons above.
- step saturates at all-ones and does not wrap. Saturation cannot occur for MODE 0, since the worst case is 2^WIDTH-2 steps.
- Latency: for N steps, done is high in the cycle beginning N+1 edges after the accepting edge. Zero-step case (e.g. 0,0): done in the cycle after the accepting edge.
- Zero operands: gcd(0,0)=0, gcd(0,b)=b, gcd(a,0)=a, all with iter_count=0.
- Handshake:
  - start while busy=1 or during DONE is ignored; inputs are not re-sampled.
  - start held continuously restarts in the IDLE cycle after DONE.
  - gcd_out/iter_count are stable from DONE until the next accepting edge, where they remain unchanged until the new DONE.
  - a_in/b_in may change freely after the accepting edge.

Test Plan:
- MODE 0: a=143, b=78, start 1 cycle -> done pulse 7 edges after accept; gcd_out=13, iter_count=6; busy low with done.
- MODE 1: a=143, b=78 -> gcd_out=13, iter_count=6. a=48, b=18 -> gcd_out=6, iter_count=6 (MODE 0: 6, iter_count=4).
- Zeros, both modes: (0,0) -> 0, iter 0, done next cycle. (0,25) -> 25. (91,0) -> 91.
- Mid-run start: a=143, b=78, then start with a=10, b=4 while busy -> ignored; result 13 delivered and held through subsequent idle cycles.
- Reset mid-run: assert rst 3 cycles after accept -> outputs 0 immediately, no done; next start with (21,14) -> 7.
- MODE 0 worst case, WIDTH=16: (65535,1) -> gcd_out=1, iter_count=65534. Random pairs checked against a reference GCD model in both modes.

Source files
------------

// File: rtl/gcd_if.sv
// Start/operand/result bundle for the GCD engine.
// The master drives the operands, the slave returns status and result.
interface gcd_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] gcd_out;
    logic [WIDTH-1:0] iter_count;

    modport master (
        output start, a_in, b_in,
        input  busy, done, gcd_out, iter_count
    );

    modport slave (
        input  start, a_in, b_in,
        output busy, done, gcd_out, iter_count
    );
endinterface

// File: rtl/gcd_unit.sv
// Iterative GCD engine, one reduction step per clock.
// MODE 0 uses subtractive Euclid, MODE 1 uses binary Stein.
module gcd_unit #(
    parameter int WIDTH = 16,
    parameter int MODE  = 0
) (
    input  logic clk,
    input  logic rst,
    gcd_if.slave bus
);
    localparam int KW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] iter_q, iter_d;
    logic [KW-1:0]    k_q, k_d;

    logic             term;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] ab_or;
    logic [WIDTH-1:0] step_inc;

    always_comb begin
        ab_or    = a_q | b_q;
        step_inc = (&step_q) ? step_q : step_q + 1'b1;
        if (MODE == 0) begin
            term   = (a_q == '0) || (b_q == '0) || (a_q == b_q);
            result = (a_q == '0) ? b_q : a_q;
        end else begin
            term   = (a_q == '0) || (b_q == '0);
            result = ab_or << k_q;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        k_d     = k_q;
        step_d  = step_q;
        res_d   = res_q;
        iter_d  = iter_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a_in;
                    b_d     = bus.b_in;
                    k_d     = '0;
                    step_d  = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (term) begin
                    res_d   = result;
                    iter_d  = step_q;
                    state_d = DONE;
                end else begin
                    step_d = step_inc;
                    if (MODE == 0) begin
                        if (a_q > b_q) a_d = a_q - b_q;
                        else           b_d = b_q - a_q;
                    end else begin
                        // Shared factors of two are counted in k and restored at the end
                        if (!a_q[0] && !b_q[0]) begin
                            a_d = a_q >> 1;
                            b_d = b_q >> 1;
                            k_d = k_q + 1'b1;
                        end else if (!a_q[0]) begin
                            a_d = a_q >> 1;
                        end else if (!b_q[0]) begin
                            b_d = b_q >> 1;
                        end else if (a_q >= b_q) begin
                            a_d = (a_q - b_q) >> 1;
                        end else begin
                            b_d = (b_q - a_q) >> 1;
                        end
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            k_q     <= '0;
            step_q  <= '0;
            res_q   <= '0;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            k_q     <= k_d;
            step_q  <= step_d;
            res_q   <= res_d;
            iter_q  <= iter_d;
        end
    end

    assign bus.busy       = (state_q == CALC);
    assign bus.done       = (state_q == DONE);
    assign bus.gcd_out    = res_q;
    assign bus.iter_count = iter_q;
endmodule

// File: tb/tb_gcd_unit.sv
// Bench for gcd_unit: one Euclid and one Stein instance side by side,
// checked against arithmetic GCD/step-count models.
module tb_gcd_unit;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    gcd_if #(.WIDTH(16)) i0 ();
    gcd_if #(.WIDTH(16)) i1 ();

    gcd_unit #(.WIDTH(16), .MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(i0.slave));
    gcd_unit #(.WIDTH(16), .MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(i1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Subtractive Euclid step count = sum of Euclid quotients minus one
    function automatic void ref_euclid(input int a, input int b, output int g, output int st);
        int q;
        int t;
        if (a == 0 || b == 0) begin
            g  = a | b;
            st = 0;
        end else begin
            q = 0;
            while (b != 0) begin
                q = q + a / b;
                t = a % b;
                a = b;
                b = t;
            end
            g  = a;
            st = q - 1;
        end
    endfunction

    function automatic void ref_stein(input int a, input int b, output int g, output int st);
        int k;
        k  = 0;
        st = 0;
        while (a != 0 && b != 0) begin
            if (a % 2 == 0 && b % 2 == 0) begin
                a = a / 2; b = b / 2; k++;
            end else if (a % 2 == 0) a = a / 2;
            else if (b % 2 == 0) b = b / 2;
            else if (a >= b) a = (a - b) / 2;
            else b = (b - a) / 2;
            st++;
        end
        g = (a | b) << k;
    endfunction

    task automatic drive(input int m, input logic s, input logic [15:0] a, input logic [15:0] b);
        if (m == 0) begin
            i0.start = s; i0.a_in = a; i0.b_in = b;
        end else begin
            i1.start = s; i1.a_in = a; i1.b_in = b;
        end
    endtask

    task automatic peek(input int m, output logic bz, output logic dn,
                        output logic [15:0] g, output logic [15:0] it);
        if (m == 0) begin
            bz = i0.busy; dn = i0.done; g = i0.gcd_out; it = i0.iter_count;
        end else begin
            bz = i1.busy; dn = i1.done; g = i1.gcd_out; it = i1.iter_count;
        end
    endtask

    // Single-cycle start, then count edges after the accepting edge until done
    task automatic run(input int m, input logic [15:0] a, input logic [15:0] b, input int limit,
                       output logic [15:0] g, output logic [15:0] it, output int lat,
                       output logic busy1, output logic busy_dn);
        logic bz, dn;
        @(negedge clk);
        drive(m, 1'b1, a, b);
        @(posedge clk);
        @(negedge clk);
        drive(m, 1'b0, 16'($urandom), 16'($urandom));
        peek(m, bz, dn, g, it);
        busy1   = bz;
        busy_dn = 1'bx;
        lat     = -1;
        for (int e = 1; e <= limit; e++) begin
            @(posedge clk);
            @(negedge clk);
            peek(m, bz, dn, g, it);
            if (dn) begin
                lat     = e;
                busy_dn = bz;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic bz, dn;
        logic [15:0] g, it;
        rst = 1'b1;
        drive(0, 1'b0, 16'd0, 16'd0);
        drive(1, 1'b0, 16'd0, 16'd0);
        repeat (2) @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            peek(m, bz, dn, g, it);
            checks++;
            if ({bz, dn, g, it} !== 34'd0) begin
                failures++;
                $display("FAIL reset m%0d: busy=%b done=%b gcd=%0d iter=%0d, want all 0", m, bz, dn, g, it);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        logic [15:0] g, it;
        int lat;
        logic b1, bd;
        int va[2]  = '{143, 48};
        int vb[2]  = '{78, 18};
        int eg[2]  = '{13, 6};
        int ei[4]  = '{6, 4, 6, 6};
        for (int m = 0; m < 2; m++) begin
            for (int v = 0; v < 2; v++) begin
                run(m, 16'(va[v]), 16'(vb[v]), 100, g, it, lat, b1, bd);
                checks++;
                if (g !== 16'(eg[v]) || it !== 16'(ei[m*2+v]) || lat != ei[m*2+v] + 1) begin
                    failures++;
                    $display("FAIL vec m%0d (%0d,%0d): gcd=%0d iter=%0d lat=%0d, want %0d %0d %0d",
                             m, va[v], vb[v], g, it, lat, eg[v], ei[m*2+v], ei[m*2+v] + 1);
                end
                checks++;
                if (b1 !== 1'b1 || bd !== 1'b0) begin
                    failures++;
                    $display("FAIL busy m%0d: busy_after_accept=%b busy_at_done=%b, want 1 0", m, b1, bd);
                end
            end
        end
    endtask

    task automatic test_zeros();
        logic [15:0] g, it;
        int lat;
        logic b1, bd;
        int za[3] = '{0, 0, 91};
        int zb[3] = '{0, 25, 0};
        for (int m = 0; m < 2; m++) begin
            for (int v = 0; v < 3; v++) begin
                run(m, 16'(za[v]), 16'(zb[v]), 10, g, it, lat, b1, bd);
                checks++;
                if (g !== 16'(za[v] | zb[v]) || it !== 16'd0 || lat != 1) begin
                    failures++;
                    $display("FAIL zero m%0d (%0d,%0d): gcd=%0d iter=%0d lat=%0d, want %0d 0 1",
                             m, za[v], zb[v], g, it, lat, za[v] | zb[v]);
                end
            end
        end
    endtask

    task automatic test_midrun_start();
        logic bz, dn;
        logic [15:0] g, it;
        int lat;
        @(negedge clk);
        drive(0, 1'b1, 16'd143, 16'd78);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b1, 16'd10, 16'd4);
        lat = -1;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 3) drive(0, 1'b0, 16'd10, 16'd4);
            peek(0, bz, dn, g, it);
            if (dn) begin
                lat = e;
                break;
            end
        end
        checks++;
        if (g !== 16'd13 || it !== 16'd6 || lat != 7) begin
            failures++;
            $display("FAIL midrun: gcd=%0d iter=%0d lat=%0d, want 13 6 7", g, it, lat);
        end
        repeat (5) @(negedge clk);
        peek(0, bz, dn, g, it);
        checks++;
        if (g !== 16'd13 || it !== 16'd6 || bz !== 1'b0 || dn !== 1'b0) begin
            failures++;
            $display("FAIL hold: gcd=%0d iter=%0d busy=%b done=%b, want 13 6 0 0", g, it, bz, dn);
        end
    endtask

    task automatic test_reset_midrun();
        logic bz, dn, seen, b1, bd;
        logic [15:0] g, it;
        int lat;
        @(negedge clk);
        drive(0, 1'b1, 16'd143, 16'd78);
        @(posedge clk);
        @(negedge clk);
        drive(0, 1'b0, 16'd0, 16'd0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        peek(0, bz, dn, g, it);
        checks++;
        if ({bz, dn, g, it} !== 34'd0) begin
            failures++;
            $display("FAIL async_rst: busy=%b done=%b gcd=%0d iter=%0d, want all 0", bz, dn, g, it);
        end
        @(negedge clk);
        rst  = 1'b0;
        seen = 1'b0;
        for (int e = 0; e < 10; e++) begin
            @(negedge clk);
            peek(0, bz, dn, g, it);
            if (dn || bz) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL rst_abandon: activity=%b after reset, want 0", seen);
        end
        run(0, 16'd21, 16'd14, 20, g, it, lat, b1, bd);
        checks++;
        if (g !== 16'd7 || it !== 16'd2 || lat != 3) begin
            failures++;
            $display("FAIL post_rst: gcd=%0d iter=%0d lat=%0d, want 7 2 3", g, it, lat);
        end
    endtask

    task automatic test_worst_case();
        logic [15:0] g, it;
        int lat;
        logic b1, bd;
        run(0, 16'd65535, 16'd1, 70000, g, it, lat, b1, bd);
        checks++;
        if (g !== 16'd1 || it !== 16'd65534 || lat != 65535) begin
            failures++;
            $display("FAIL worst: gcd=%0d iter=%0d lat=%0d, want 1 65534 65535", g, it, lat);
        end
    endtask

    task automatic test_random();
        logic [15:0] g, it;
        int lat, a, b, eg, es;
        logic b1, bd;
        for (int m = 0; m < 2; m++) begin
            for (int n = 0; n < 25; n++) begin
                if (m == 0) begin
                    a = $urandom_range(0, 255);
                    b = $urandom_range(0, 255);
                    ref_euclid(a, b, eg, es);
                end else begin
                    a = int'($urandom_range(0, 65535));
                    b = int'($urandom_range(0, 65535));
                    if (n % 5 == 0) b = b & ~32'h3F;
                    ref_stein(a, b, eg, es);
                end
                run(m, 16'(a), 16'(b), 400, g, it, lat, b1, bd);
                checks++;
                if (g !== 16'(eg) || it !== 16'(es) || lat != es + 1) begin
                    failures++;
                    $display("FAIL rand m%0d (%0d,%0d): gcd=%0d iter=%0d lat=%0d, want %0d %0d %0d",
                             m, a, b, g, it, lat, eg, es, es + 1);
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_vectors();
        test_zeros();
        test_midrun_start();
        test_reset_midrun();
        test_worst_case();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
